btn_step_ctrl: RTL and testbench
================================

BTN_STEP_CTRL -- requirements
Module: btn_step_ctrl

Interface
REQ-001 Parameter: DEB_CYCLES, 500000, consecutive stable cycles required to accept a key or switch change (10 ms at 50 MHz); legal range 2..2^24-1.
REQ-002 Parameter: REPEAT_DELAY, 25000000, cycles a key is held after its accepted press before the first auto-repeat step.
REQ-003 Parameter: REPEAT_PERIOD, 10000000, cycles between subsequent auto-repeat steps.
REQ-004 clk  input  1  system clock, all logic on posedge.
REQ-005 rst  input  1  reset, synchronous, active-low.
REQ-006 key_n  input  1  raw asynchronous push-button, active-low (0 = pressed).
REQ-007 sw_dir  input  1  raw asynchronous direction switch (1 = down, 0 = up).
REQ-008 step  output  1  one-cycle pulse requesting one count step from the downstream counter.
REQ-009 dir  output  1  debounced direction, valid whenever step is high.
REQ-010 pressed  output  1  debounced key level (1 = held).

Function
REQ-011 key_n and sw_dir SHALL each pass through a 2-flop synchronizer before any other use.
REQ-012 Key FSM states SHALL be IDLE, PRESS_DEB, HELD, REL_DEB, plus REPEAT when AUTO_REPEAT_EN is defined.
REQ-013 IDLE: synchronized key low -> PRESS_DEB with debounce counter cleared; otherwise stay.
REQ-014 PRESS_DEB: key high in any cycle -> IDLE; key low for DEB_CYCLES consecutive cycles -> HELD.
REQ-015 Transition PRESS_DEB->HELD SHALL register step=1 for exactly the next cycle; latency from the first raw key_n low sample to step high SHALL be DEB_CYCLES+3 cycles.
REQ-016 HELD: key high -> REL_DEB; no further steps are generated (without AUTO_REPEAT_EN).
REQ-017 REL_DEB: key low in any cycle -> HELD; key high for DEB_CYCLES consecutive cycles -> IDLE; no step is generated on release.
REQ-018 pressed SHALL be 1 in HELD, REL_DEB and REPEAT, 0 otherwise.
REQ-019 dir SHALL use an independent stable-for-DEB_CYCLES debouncer; the debounced value SHALL update into dir only while the key FSM is IDLE, so dir is constant from press through release.
REQ-020 A dir change pending while the key is held SHALL be applied within one cycle of returning to IDLE if still stable.
REQ-021 Debounce counters SHALL saturate at DEB_CYCLES and never wrap.
REQ-022 step SHALL never be high in two consecutive cycles.

Reset
REQ-023 With rst=0 at a clock edge: FSM -> IDLE, all counters -> 0, synchronizers -> 1 (key released), step=0, pressed=0, dir=0.
REQ-024 Reset asserted mid-debounce or mid-hold SHALL abort without emitting step; after release a held key SHALL be re-debounced from IDLE.

Configuration
REQ-025 Macro BTN_STEP_AUTO_REPEAT_EN: when defined, HELD for REPEAT_DELAY cycles -> REPEAT, emitting one step on entry and then one every REPEAT_PERIOD cycles while the key stays low; key high in REPEAT -> REL_DEB.
REQ-026 Without BTN_STEP_AUTO_REPEAT_EN, the REPEAT state, repeat counter, REPEAT_DELAY and REPEAT_PERIOD logic SHALL be absent, and one press SHALL produce exactly one step.

Structure
REQ-027 Package btn_step_pkg SHALL hold the FSM state enum typedef and the default values of DEB_CYCLES, REPEAT_DELAY and REPEAT_PERIOD.
REQ-028 Sub-module sync_debounce (2-flop synchronizer plus stable counter, 1-bit) SHALL be used for sw_dir; the key path keeps its counter inside the FSM.
REQ-029 step and dir SHALL connect directly to the downstream counter's enable and direction inputs, with the counter advancing only when step=1.

Verification (DEB_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8)
REQ-030 Clean press: key_n low for 30 cycles -> single step at cycle 7 after the first low sample, pressed=1 from cycle 7; release -> pressed=0 after 4+3 cycles, no step.
REQ-031 Bounce: key_n toggles low/high every 2 cycles for 20 cycles then stays high -> step never asserts, pressed stays 0.
REQ-032 Direction lock: sw_dir changes 1 while key held -> dir stays 0 until IDLE, then reads 1; the next press gives step with dir=1.
REQ-033 Reset mid-press: rst=0 during PRESS_DEB cycle 2 -> no step; key held through release of rst -> step exactly DEB_CYCLES+3 cycles after rst=1.
REQ-034 Auto-repeat (macro defined): hold 60 cycles -> steps at the press step, +20, +28, +36, +44, +52; macro undefined -> exactly one step.

Source files
------------

// File: rtl/btn_step_pkg.sv
// btn_step_pkg: shared types and default timing for the push-button step controller.
// Optional build macro BTN_STEP_AUTO_REPEAT_EN adds the REPEAT state to the key FSM.
// Defaults assume a 50 MHz clock (10 ms debounce, 0.5 s repeat delay, 0.2 s repeat period).
package btn_step_pkg;

  // Debounce counters are this wide; DEB_CYCLES must fit (max 2^24-1).
  localparam int DEB_W = 24;

  localparam int DEB_CYCLES_DEF    = 500000;
  localparam int REPEAT_DELAY_DEF  = 25000000;
  localparam int REPEAT_PERIOD_DEF = 10000000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRESS_DEB,
    ST_HELD,
    ST_REL_DEB
`ifdef BTN_STEP_AUTO_REPEAT_EN
    , ST_REPEAT
`endif
  } key_state_e;

endpackage

// File: rtl/btn_step_if.sv
// btn_step_if: raw button/switch inputs and step/dir/pressed outputs of the controller.
// master = board/bench side driving raw inputs, slave = btn_step_ctrl.
// No handshake: step is a single-cycle strobe, dir/pressed are levels.
interface btn_step_if;
  logic key_n;    // raw push-button, active-low
  logic sw_dir;   // raw direction switch, 1 = down
  logic step;     // one-cycle step request
  logic dir;      // debounced direction, stable from press through release
  logic pressed;  // debounced key level

  modport master (output key_n, output sw_dir, input step, input dir, input pressed);
  modport slave  (input key_n, input sw_dir, output step, output dir, output pressed);
endinterface

// File: rtl/btn_step_ctrl_sync_debounce.sv
// sync_debounce: 2-flop synchronizer followed by a stable-for-DEB_CYCLES filter (1 bit).
// Latency: 2 sync cycles + DEB_CYCLES stable cycles before dout_o follows a change.
// No backpressure; input is a free-running level.
module sync_debounce
  import btn_step_pkg::*;
#(
  parameter int   DEB_CYCLES = DEB_CYCLES_DEF,
  parameter logic SYNC_RST   = 1'b1,
  parameter logic OUT_RST    = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din_i,
  output logic dout_o
);

  logic [1:0]       sync_q;
  logic [DEB_W-1:0] cnt_q, cnt_d;
  logic             dout_q, dout_d;

  // Synchronizer shift, stable counter and debounced output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q <= {2{SYNC_RST}};
      cnt_q  <= '0;
      dout_q <= OUT_RST;
    end else begin
      sync_q <= {sync_q[0], din_i};
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
    end
  end

  // Count consecutive cycles the synchronized input differs from the output; any agreement restarts.
  always_comb begin
    cnt_d  = '0;
    dout_d = dout_q;
    if (sync_q[1] != dout_q) begin
      if (cnt_q >= DEB_W'(DEB_CYCLES - 1)) begin
        dout_d = sync_q[1];
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign dout_o = dout_q;

endmodule

// File: rtl/btn_step_ctrl.sv
// btn_step_ctrl: debounced push-button to single-cycle step strobe plus locked direction.
// Latency: first raw key_n low sample to step = DEB_CYCLES+3 cycles; release produces no step.
// No backpressure; build with BTN_STEP_AUTO_REPEAT_EN for held-key auto-repeat steps.
module btn_step_ctrl
  import btn_step_pkg::*;
#(
  parameter int DEB_CYCLES    = DEB_CYCLES_DEF,
  parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
  input logic       clk,
  input logic       rst,
  btn_step_if.slave btn_if
);

  // Elaboration-time range checks on the timing parameters.
  if (DEB_CYCLES < 2 || DEB_CYCLES > (2**DEB_W) - 1) begin : g_bad_deb
    $error("DEB_CYCLES out of range 2..2^24-1");
  end
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 2) begin : g_bad_rep
    $error("REPEAT_DELAY must be >= 1 and REPEAT_PERIOD >= 2");
  end

  logic [1:0]       key_sync_q;
  logic             key_s;
  key_state_e       state_q, state_d;
  logic [DEB_W-1:0] cnt_q, cnt_d;
  logic             step_q, step_d;
  logic             dir_q;
  logic             dir_deb;
`ifdef BTN_STEP_AUTO_REPEAT_EN
  logic [31:0]      rep_q, rep_d;
  logic             rep_wrap;
`endif

  assign key_s = key_sync_q[1];

  sync_debounce #(
    .DEB_CYCLES (DEB_CYCLES),
    .SYNC_RST   (1'b1),
    .OUT_RST    (1'b0)
  ) u_dir_deb (
    .clk    (clk),
    .rst    (rst),
    .din_i  (btn_if.sw_dir),
    .dout_o (dir_deb)
  );

  // Key synchronizer plus FSM state, debounce counter and step strobe registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      key_sync_q <= 2'b11;
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      step_q     <= 1'b0;
    end else begin
      key_sync_q <= {key_sync_q[0], btn_if.key_n};
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      step_q     <= step_d;
    end
  end

`ifdef BTN_STEP_AUTO_REPEAT_EN
  // Repeat counter: held time before the first repeat, then spacing between repeats.
  always_ff @(posedge clk) begin
    if (!rst) rep_q <= '0;
    else      rep_q <= rep_d;
  end

  assign rep_wrap = (rep_q == 32'(REPEAT_PERIOD - 1));
`endif

  // Next-state: each debounce phase needs DEB_CYCLES consecutive agreeing cycles; counter stops there.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
`ifdef BTN_STEP_AUTO_REPEAT_EN
    rep_d   = rep_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!key_s) begin
          state_d = ST_PRESS_DEB;
          cnt_d   = '0;
        end
      end
      ST_PRESS_DEB: begin
        if (key_s) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q >= DEB_W'(DEB_CYCLES)) begin
          state_d = ST_HELD;
          cnt_d   = '0;
`ifdef BTN_STEP_AUTO_REPEAT_EN
          rep_d   = '0;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HELD: begin
        if (key_s) begin
          state_d = ST_REL_DEB;
          cnt_d   = '0;
        end
`ifdef BTN_STEP_AUTO_REPEAT_EN
        else if (rep_q == 32'(REPEAT_DELAY - 1)) begin
          state_d = ST_REPEAT;
          rep_d   = '0;
        end else begin
          rep_d = rep_q + 1'b1;
        end
`endif
      end
      ST_REL_DEB: begin
        if (!key_s) begin
          state_d = ST_HELD;
          cnt_d   = '0;
`ifdef BTN_STEP_AUTO_REPEAT_EN
          rep_d   = '0;
`endif
        end else if (cnt_q >= DEB_W'(DEB_CYCLES)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef BTN_STEP_AUTO_REPEAT_EN
      ST_REPEAT: begin
        if (key_s) begin
          state_d = ST_REL_DEB;
          cnt_d   = '0;
        end else if (rep_wrap) begin
          rep_d = '0;
        end else begin
          rep_d = rep_q + 1'b1;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs: step on accepted press (and repeat events), pressed while the key is debounced down.
  always_comb begin
    step_d = (state_q == ST_PRESS_DEB) && (state_d == ST_HELD);
`ifdef BTN_STEP_AUTO_REPEAT_EN
    step_d = step_d
           || ((state_q == ST_HELD)   && (state_d == ST_REPEAT))
           || ((state_q == ST_REPEAT) && (state_d == ST_REPEAT) && rep_wrap);
    btn_if.pressed = (state_q == ST_HELD) || (state_q == ST_REL_DEB) || (state_q == ST_REPEAT);
`else
    btn_if.pressed = (state_q == ST_HELD) || (state_q == ST_REL_DEB);
`endif
  end

  // Direction only follows the debounced switch while idle, so it is frozen across a press.
  always_ff @(posedge clk) begin
    if (!rst)                    dir_q <= 1'b0;
    else if (state_q == ST_IDLE) dir_q <= dir_deb;
  end

  assign btn_if.step = step_q;
  assign btn_if.dir  = dir_q;

endmodule

// File: tb/tb_btn_step_ctrl.sv
// tb_btn_step_ctrl: directed bench for btn_step_ctrl with DEB_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8.
// Cycle index 0 is the first clock edge that samples a new raw input value.
// Expectations switch on BTN_STEP_AUTO_REPEAT_EN to match the build.
module tb_btn_step_ctrl;

  localparam int DEB = 4;
  localparam int RD  = 20;
  localparam int RP  = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  btn_step_if bus ();

  btn_step_ctrl #(
    .DEB_CYCLES    (DEB),
    .REPEAT_DELAY  (RD),
    .REPEAT_PERIOD (RP)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .btn_if (bus)
  );

  int   n_chk = 0;
  int   n_err = 0;
  int   cyc;
  int   steps[$];
  int   step_dirs[$];
  logic pr_h [0:127];
  logic dir_h[0:127];
  bit   prev_step = 1'b0;
  int   consec = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock and record outputs 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.step === 1'b1) begin
      steps.push_back(cyc);
      step_dirs.push_back(int'(bus.dir));
      if (prev_step) consec++;
    end
    prev_step = (bus.step === 1'b1);
    if (cyc < 128) begin
      pr_h[cyc]  = bus.pressed;
      dir_h[cyc] = bus.dir;
    end
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic phase();
    cyc = 0;
    steps.delete();
    step_dirs.delete();
  endtask

  function automatic int first_step();
    return (steps.size() > 0) ? steps[0] : -1;
  endfunction

  function automatic int first_dir();
    return (step_dirs.size() > 0) ? step_dirs[0] : -1;
  endfunction

  int  exp_rep[$];
  int  n_press30;
  bit  any_pr;

  initial begin
`ifdef BTN_STEP_AUTO_REPEAT_EN
    exp_rep   = '{7, 27, 35, 43, 51, 59};
    n_press30 = 2;
`else
    exp_rep   = '{7};
    n_press30 = 1;
`endif
    bus.key_n  = 1'b1;
    bus.sw_dir = 1'b0;
    rst        = 1'b0;
    cyc        = 0;

    // Reset state
    run(3);
    check("rst_step", 32'(bus.step), 0);
    check("rst_pressed", 32'(bus.pressed), 0);
    check("rst_dir", 32'(bus.dir), 0);
    rst = 1'b1;
    run(5);

    // Clean press for 30 cycles, then release
    phase();
    bus.key_n = 1'b0;
    run(30);
    check("press_step_at", 32'(first_step()), 7);
    check("press_nsteps", 32'(steps.size()), 32'(n_press30));
    check("press_pr6", 32'(pr_h[6]), 0);
    check("press_pr7", 32'(pr_h[7]), 1);
    check("press_dir", 32'(first_dir()), 0);
    phase();
    bus.key_n = 1'b1;
    run(12);
    check("rel_pr6", 32'(pr_h[6]), 1);
    check("rel_pr7", 32'(pr_h[7]), 0);
    check("rel_nsteps", 32'(steps.size()), 0);

    // Bounce: 2 low / 2 high for 20 cycles, then high
    phase();
    for (int i = 0; i < 5; i++) begin
      bus.key_n = 1'b0;
      run(2);
      bus.key_n = 1'b1;
      run(2);
    end
    run(10);
    any_pr = 1'b0;
    for (int i = 0; i < 30; i++) any_pr = any_pr | pr_h[i];
    check("bounce_nsteps", 32'(steps.size()), 0);
    check("bounce_pressed", 32'(any_pr), 0);

    // Direction lock: switch flips while held, applies only after release reaches idle
    phase();
    bus.key_n = 1'b0;
    run(10);
    bus.sw_dir = 1'b1;
    run(15);
    check("lock_step_dir", 32'(first_dir()), 0);
    check("lock_dir_held", 32'(dir_h[24]), 0);
    phase();
    bus.key_n = 1'b1;
    run(12);
    check("lock_dir_c7", 32'(dir_h[7]), 0);
    check("lock_dir_c8", 32'(dir_h[8]), 1);
    run(3);
    phase();
    bus.key_n = 1'b0;
    run(12);
    check("lock2_step_at", 32'(first_step()), 7);
    check("lock2_step_dir", 32'(first_dir()), 1);
    bus.key_n = 1'b1;
    run(12);

    // Reset during press debounce, key kept low across reset release
    phase();
    bus.key_n = 1'b0;
    run(4);
    rst = 1'b0;
    run(3);
    check("rstm_nsteps", 32'(steps.size()), 0);
    check("rstm_pressed", 32'(pr_h[6]), 0);
    rst = 1'b1;
    phase();
    run(12);
    check("rstm_step_at", 32'(first_step()), 7);
    check("rstm_nsteps2", 32'(steps.size()), 1);
    check("rstm_pr6", 32'(pr_h[6]), 0);
    bus.key_n = 1'b1;
    run(12);

    // Long hold: one step, or auto-repeat pattern when enabled
    phase();
    bus.key_n = 1'b0;
    run(60);
    bus.key_n = 1'b1;
    run(12);
    check("hold_nsteps", 32'(steps.size()), 32'(exp_rep.size()));
    for (int i = 0; i < exp_rep.size(); i++) begin
      check($sformatf("hold_step%0d", i), (i < steps.size()) ? 32'(steps[i]) : 32'hFFFF_FFFF,
            32'(exp_rep[i]));
    end

    check("no_back_to_back", 32'(consec), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
